mbr_bus_unit: RTL and testbench
===============================

MBR_BUS_UNIT -- requirements
Module: mbr_bus_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 16, buffer and bus data width.
- CTRL_W, 32, control word width.
- BIT_ACC, 19, control bit for MBR<-ACC.
- BIT_RD, 17, control bit for MBR<-memory (handshaked read).
- BIT_WR, 18, control bit for memory<-MBR (handshaked write).
- TIMEOUT, 15, maximum wait cycles for mem_ready; must be >=1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- control_signal, in, CTRL_W: micro-op control word.
- ACC_in, in, DATA_W: accumulator data.
- mem_in, in, DATA_W: memory read data.
- mem_ready, in, 1: memory completion strobe.
- mem_req, out, 1: memory access request.
- mem_we, out, 1: 1 = write, 0 = read; valid while mem_req=1.
- mem_out, out, DATA_W: write data to memory, always equal to the buffer.
- reg_out, out, DATA_W: buffer to MAR/PC/IR/BR, always equal to the buffer.
- busy, out, 1: high when state != IDLE.
- done, out, 1: one-cycle completion pulse.
- timeout_err, out, 1: sticky abort flag.

Function
REQ-003 The block SHALL hold one DATA_W buffer register; mem_out and reg_out SHALL be combinational copies of it.
REQ-004 The FSM SHALL have states IDLE, READ and WRITE; busy SHALL be 1 in READ and WRITE.
REQ-005 In IDLE, commands SHALL be accepted on a rising edge with priority BIT_ACC > BIT_RD > BIT_WR; lower-priority bits set in the same cycle SHALL be dropped.
REQ-006 ACC load:
- buffer <= ACC_in at the accepting edge.
- State remains IDLE.
- done SHALL be 1 for the following cycle.
REQ-007 Read:
- Accepting edge SHALL enter READ.
- mem_req=1 and mem_we=0 throughout READ.
- At the first edge in READ with mem_ready=1: buffer <= mem_in, return to IDLE, mem_req=0, done=1 for one cycle.
REQ-008 Write:
- Accepting edge SHALL enter WRITE.
- mem_req=1 and mem_we=1 throughout WRITE; mem_out holds the buffer value, unchanged.
- At the first edge with mem_ready=1: return to IDLE, done=1 for one cycle; buffer unchanged.
REQ-009 Minimum latency SHALL be 2 edges from command acceptance to done (mem_ready=1 on the first edge in READ/WRITE).
REQ-010 Timeout counter:
- Width ceil(log2(TIMEOUT+1)).
- Cleared on entry to READ/WRITE.
- Increments on each edge in READ/WRITE with mem_ready=0.
REQ-011 Timeout abort:
- On the edge where the counter would reach TIMEOUT, the FSM SHALL return to IDLE.
- timeout_err SHALL be set.
- done SHALL NOT pulse.
- buffer SHALL be unchanged.
REQ-012 If mem_ready=1 on the same edge the timeout would fire, completion SHALL win (no error).
REQ-013 timeout_err SHALL remain 1 until the next accepted command, which SHALL clear it at its accepting edge.
REQ-014 control_signal SHALL be ignored while busy=1; commands are not queued.
REQ-015 mem_ready SHALL be ignored in IDLE.
REQ-016 mem_req and mem_we SHALL be registered-state decodes, free of combinational paths from inputs.
REQ-017 done SHALL be registered, and SHALL never be 1 while busy=1.

Reset
REQ-018 rst_n=0 SHALL asynchronously force:
- state = IDLE;
- buffer, counter = 0;
- mem_req, mem_we, done, timeout_err = 0.
REQ-019 Reset asserted mid-READ/WRITE SHALL abort the transaction with no done pulse and no buffer update.
REQ-020 After rst_n deasserts, the first rising edge SHALL be able to accept a command.

Verification
REQ-021 ACC load: ACC_in=16'h1234, bit19 for one cycle -> reg_out=16'h1234 after that edge, done=1 for one cycle, busy stays 0.
REQ-022 Read with 3 wait states: bit17 pulse, mem_ready low 3 edges then high with mem_in=16'hBEEF -> mem_req=1/mem_we=0 for 4 cycles, reg_out=16'hBEEF, done pulse, busy=0.
REQ-023 Write: buffer=16'h00A5, bit18 pulse, mem_ready high on 1st edge -> mem_we=1 for one cycle, mem_out=16'h00A5, done pulse.
REQ-024 Timeout: bit17 pulse, mem_ready held 0 -> after 15 edges in READ, return to IDLE, timeout_err=1, reg_out unchanged, no done; next bit19 clears timeout_err.
REQ-025 Priority and busy: bits 19 and 17 together -> ACC load only; bit18 asserted during READ -> ignored, no WRITE follows.
REQ-026 Reset mid-read: rst_n=0 while in READ -> mem_req=0, reg_out=0, busy=0 immediately; no done after release.

Source files
------------

// File: rtl/mbr_bus_unit.sv
// Memory buffer register with ACC load and handshaked memory read/write.
// Three-state FSM with a wait-state timeout that aborts to IDLE and sets a sticky error.
module mbr_bus_unit #(
   parameter int DATA_W  = 16,
   parameter int CTRL_W  = 32,
   parameter int BIT_ACC = 19,
   parameter int BIT_RD  = 17,
   parameter int BIT_WR  = 18,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] control_signal,
   input  logic [DATA_W-1:0] ACC_in,
   input  logic [DATA_W-1:0] mem_in,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_out,
   output logic [DATA_W-1:0] reg_out,
   output logic              busy,
   output logic              done,
   output logic              timeout_err
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t            state;
   logic [DATA_W-1:0] buffer;
   logic [CNT_W-1:0]  wait_cnt;
   logic              cmd_acc, cmd_rd, cmd_wr;
   logic              unused_ctrl;

   assign cmd_acc     = control_signal[BIT_ACC];
   assign cmd_rd      = control_signal[BIT_RD];
   assign cmd_wr      = control_signal[BIT_WR];
   assign unused_ctrl = ^control_signal;

   assign mem_out = buffer;
   assign reg_out = buffer;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         buffer      <= '0;
         wait_cnt    <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_acc) begin
                  buffer      <= ACC_in;
                  done        <= 1'b1;
                  timeout_err <= 1'b0;
               end else if (cmd_rd) begin
                  state       <= READ;
                  wait_cnt    <= '0;
                  mem_req     <= 1'b1;
                  mem_we      <= 1'b0;
                  timeout_err <= 1'b0;
               end else if (cmd_wr) begin
                  state       <= WRITE;
                  wait_cnt    <= '0;
                  mem_req     <= 1'b1;
                  mem_we      <= 1'b1;
                  timeout_err <= 1'b0;
               end
            end
            READ, WRITE: begin
               // Completion is tested first so a ready on the timeout edge wins.
               if (mem_ready) begin
                  if (state == READ) buffer <= mem_in;
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                     state       <= IDLE;
                     mem_req     <= 1'b0;
                     mem_we      <= 1'b0;
                     timeout_err <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbr_bus_unit.sv
// Directed bench for mbr_bus_unit: vector table for command sequences,
// hand-written sequences for timeout, completion-vs-timeout and mid-read reset.
module tb_mbr_bus_unit;

   localparam logic [31:0] C_ACC = 32'h0008_0000;
   localparam logic [31:0] C_RD  = 32'h0002_0000;
   localparam logic [31:0] C_WR  = 32'h0004_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] control_signal;
   logic [15:0] ACC_in, mem_in, mem_out, reg_out;
   logic        mem_ready, mem_req, mem_we, busy, done, timeout_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mbr_bus_unit #(.DATA_W(16), .CTRL_W(32), .BIT_ACC(19), .BIT_RD(17),
                  .BIT_WR(18), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .control_signal(control_signal),
      .ACC_in(ACC_in), .mem_in(mem_in), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_out(mem_out),
      .reg_out(reg_out), .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   typedef struct {
      logic [31:0] ctrl;
      logic [15:0] acc;
      logic [15:0] min;
      logic        rdy;
      logic [15:0] e_reg;
      logic        e_busy, e_done, e_req, e_we, e_err;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [15:0] e_reg, input logic e_busy,
                            input logic e_done, input logic e_req, input logic e_we,
                            input logic e_err);
      check({name, ".reg_out"}, reg_out, e_reg);
      check({name, ".mem_out"}, mem_out, e_reg);
      check({name, ".busy"}, 16'(busy), 16'(e_busy));
      check({name, ".done"}, 16'(done), 16'(e_done));
      check({name, ".mem_req"}, 16'(mem_req), 16'(e_req));
      check({name, ".mem_we"}, 16'(mem_we), 16'(e_we));
      check({name, ".timeout_err"}, 16'(timeout_err), 16'(e_err));
   endtask

   task automatic step(input logic [31:0] ctrl, input logic [15:0] acc,
                       input logic [15:0] min, input logic rdy);
      control_signal = ctrl;
      ACC_in         = acc;
      mem_in         = min;
      mem_ready      = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            ctrl          acc       min       rdy   reg       bsy  dn   req  we   err
      vecs[0]  = '{C_ACC,        16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[1]  = '{32'h0,        16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[2]  = '{C_RD,         16'h0000, 16'hDEAD, 1'b1, 16'h1234, 1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[3]  = '{32'h0,        16'h0000, 16'hBEEF, 1'b0, 16'h1234, 1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[4]  = '{32'h0,        16'h0000, 16'hBEEF, 1'b0, 16'h1234, 1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[5]  = '{32'h0,        16'h0000, 16'hBEEF, 1'b0, 16'h1234, 1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[6]  = '{32'h0,        16'h0000, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[7]  = '{32'h0,        16'h0000, 16'h0000, 1'b0, 16'hBEEF, 1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[8]  = '{C_ACC,        16'h00A5, 16'h0000, 1'b0, 16'h00A5, 1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[9]  = '{C_WR,         16'h0000, 16'h0000, 1'b0, 16'h00A5, 1'b1,1'b0,1'b1,1'b1,1'b0};
      vecs[10] = '{32'h0,        16'h0000, 16'hFFFF, 1'b1, 16'h00A5, 1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[11] = '{C_ACC | C_RD, 16'h5555, 16'h0000, 1'b0, 16'h5555, 1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[12] = '{32'h0,        16'h0000, 16'h0000, 1'b0, 16'h5555, 1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[13] = '{C_RD,         16'h0000, 16'h0000, 1'b0, 16'h5555, 1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[14] = '{C_WR,         16'h0000, 16'h0000, 1'b0, 16'h5555, 1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[15] = '{C_WR,         16'h0000, 16'h1111, 1'b1, 16'h1111, 1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[16] = '{32'h0,        16'h0000, 16'h0000, 1'b0, 16'h1111, 1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[17] = '{C_RD | C_WR,  16'h0000, 16'h0000, 1'b1, 16'h1111, 1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[18] = '{32'h0,        16'h0000, 16'h2222, 1'b1, 16'h2222, 1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[19] = '{C_ACC,        16'h0F0F, 16'h9999, 1'b1, 16'h0F0F, 1'b0,1'b1,1'b0,1'b0,1'b0};

      rst_n = 1'b0;
      control_signal = '0;
      ACC_in = '0;
      mem_in = '0;
      mem_ready = 1'b0;
      #12;
      check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].ctrl, vecs[i].acc, vecs[i].min, vecs[i].rdy);
         check_all($sformatf("vec%0d", i), vecs[i].e_reg, vecs[i].e_busy, vecs[i].e_done,
                   vecs[i].e_req, vecs[i].e_we, vecs[i].e_err);
      end

      // Read timeout: 15 edges in READ with mem_ready low.
      step(C_RD, 16'h0000, 16'hAAAA, 1'b0);
      check_all("to_rd_enter", 16'h0F0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k < 15; k++) begin
         step(32'h0, 16'h0000, 16'hAAAA, 1'b0);
         check_all($sformatf("to_rd_wait%0d", k), 16'h0F0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      step(32'h0, 16'h0000, 16'hAAAA, 1'b0);
      check_all("to_rd_abort", 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(32'h0, 16'h0000, 16'hAAAA, 1'b1);
      check_all("to_sticky", 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(C_ACC, 16'h7777, 16'h0000, 1'b0);
      check_all("to_clear", 16'h7777, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Ready arriving on the edge the timeout would fire: completion wins.
      step(C_RD, 16'h0000, 16'h0000, 1'b0);
      for (int k = 1; k < 15; k++) step(32'h0, 16'h0000, 16'h0000, 1'b0);
      check_all("race_pre", 16'h7777, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(32'h0, 16'h0000, 16'h3333, 1'b1);
      check_all("race_done", 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Write timeout leaves the buffer alone.
      step(C_WR, 16'h0000, 16'h0000, 1'b0);
      for (int k = 1; k < 15; k++) step(32'h0, 16'h0000, 16'h0000, 1'b0);
      check_all("to_wr_pre", 16'h3333, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(32'h0, 16'h0000, 16'h0000, 1'b0);
      check_all("to_wr_abort", 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a read.
      step(C_RD, 16'h0000, 16'h0000, 1'b0);
      step(32'h0, 16'h0000, 16'h0000, 1'b0);
      check_all("rst_pre", 16'h3333, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_all("rst_async", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(32'h0, 16'h0000, 16'h4444, 1'b1);
      rst_n = 1'b1;
      step(32'h0, 16'h0000, 16'h4444, 1'b1);
      check_all("rst_after", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(C_ACC, 16'h6666, 16'h0000, 1'b0);
      check_all("rst_accept", 16'h6666, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
